// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the core front end.
// Holds next-PC select codes, the NOP encoding, fetch FSM states and the fetch-buffer entry type.
package riscv_pkg;

    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_ALU    = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} entries with flush.
// Ports: clk, reset (sync, active high), push/push_data, pop, flush, head (oldest entry), count.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic [63:0]                      push_data,
    input  logic                             pop,
    input  logic                             flush,
    output logic [63:0]                      head,
    output logic [$clog2(DEPTH + 1) - 1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

    // Head comes straight from registered storage: no write-through bypass.
    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, issues in-order imem requests, buffers responses for decode.
// Ports: clk/reset, retire+PCSrc/PCTarget/ALUResult redirect, imem req/ready/rvalid bus,
// Instr/PC/PCPlus4/InstrValid to decode, sticky MisalignFault.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        retire,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] PCTarget,
    input  logic [31:0] ALUResult,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        InstrValid,
    output logic        MisalignFault
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    fetch_state_t   state;
    fetch_state_t   state_next;
    logic [31:0]    fetch_pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  drop;
    logic [CW-1:0]  count;
    logic [CW-1:0]  out_after;
    logic           fault;
    logic           running;
    logic           accept;
    logic           resp_ok;
    logic           head_valid;
    logic           redirect;
    logic           misalign;
    logic           push;
    logic           pop;
    logic [31:0]    target;
    fetch_entry_t   push_entry;
    fetch_entry_t   head_entry;

    assign running  = (state == RUN) && !reset;
    assign imem_req = running &&
                      ((SW'(outstanding) + SW'(count)) < SW'(DEPTH));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;

    // A response with nothing in flight is a protocol error and is dropped.
    assign resp_ok = running && imem_rvalid && (outstanding != '0);

    assign head_valid = (count != '0) && (state != FAULT) && !reset;
    assign redirect   = retire && head_valid &&
                        ((PCSrc == PCSRC_TARGET) || (PCSrc == PCSRC_ALU));

    always_comb begin
        target = PCTarget;
        unique case (PCSrc)
            // JALR: clear bit 0 of the ALU result.
            PCSRC_ALU: target = ALUResult ^ {31'b0, ALUResult[0]};
            default:   target = PCTarget;
        endcase
    end

    assign misalign = target[1];

    assign push = resp_ok && !redirect;
    assign pop  = retire && head_valid && !redirect;

    // Requests are sequential, so the oldest in-flight address is
    // fetch_pc minus four per outstanding request.
    assign push_entry.pc    = fetch_pc - (32'(outstanding) << 2);
    assign push_entry.instr = imem_rdata;

    assign out_after = outstanding + CW'(accept) - CW'(resp_ok);

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head_entry),
        .count     (count)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (redirect) begin
                    if (misalign)
                        state_next = FAULT;
                    else if (out_after != '0)
                        state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((drop == '0) ||
                    (imem_rvalid && (drop == CW'(1))))
                    state_next = RUN;
            end
            FAULT:   state_next = FAULT;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fault       <= 1'b0;
        end else begin
            state <= state_next;
            if (redirect) begin
                // Everything still in flight, including a request
                // accepted this cycle, belongs to the wrong path.
                fetch_pc    <= target;
                outstanding <= '0;
                drop        <= misalign ? '0 : out_after;
                if (misalign) fault <= 1'b1;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                outstanding <= out_after;
                if ((state == DRAIN) && imem_rvalid && (drop != '0))
                    drop <= drop - CW'(1);
            end
        end
    end

    assign InstrValid    = head_valid;
    assign Instr         = head_valid ? head_entry.instr : NOP_INSTR;
    assign PC            = head_valid ? head_entry.pc : 32'd0;
    assign PCPlus4       = PC + 32'd4;
    assign MisalignFault = fault && !reset;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random stimulus against a program-flow reference model.
// The driver pushes expected {pc, instr} per retire; a negedge monitor pops and compares.
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        retire;
    logic [1:0]  PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] ALUResult;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        InstrValid;
    logic        MisalignFault;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC(RESET_PC),
        .DEPTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .retire       (retire),
        .PCSrc        (PCSrc),
        .PCTarget     (PCTarget),
        .ALUResult    (ALUResult),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .Instr        (Instr),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .InstrValid   (InstrValid),
        .MisalignFault(MisalignFault)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memreq_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_pct = 100;
    int          acc_count = 0;
    int          rv_count = 0;
    logic [31:0] model_pc = RESET_PC;
    memreq_t     memq[$];
    logic [31:0] sb_pc[$];
    logic [31:0] sb_instr[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic check_b(input string name, input logic act,
                           input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Ends the current cycle: records what the coming edge will do,
    // then advances and drives the memory response for the new cycle.
    task automatic tick();
        #1;
        if (!reset) begin
            if (imem_req && imem_ready) begin
                memq.push_back('{imem_addr,
                    cyc + int'($urandom_range(lat_max, lat_min))});
                acc_count++;
            end
            if (retire && InstrValid) begin
                sb_pc.push_back(model_pc);
                sb_instr.push_back(mem_word(model_pc));
                case (PCSrc)
                    2'b01:   model_pc = PCTarget;
                    2'b10:   model_pc = {ALUResult[31:1], 1'b0};
                    default: model_pc = model_pc + 32'd4;
                endcase
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
        imem_ready  = ($urandom_range(99, 0) < ready_pct);
        if (reset) begin
            memq.delete();
        end else if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(memq[0].addr);
            void'(memq.pop_front());
            rv_count++;
        end
        assert (rv_count <= acc_count)
            else $error("response without an accepted request");
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        retire = 1'b0;
        PCSrc  = PCSRC_PLUS4;
        tick();
        tick();
        check_b("rst_valid", InstrValid, 1'b0);
        check("rst_instr", Instr, NOP_INSTR);
        check("rst_pc", PC, 32'd0);
        check_b("rst_fault", MisalignFault, 1'b0);
        sb_pc.delete();
        sb_instr.delete();
        model_pc = RESET_PC;
        reset = 1'b0;
        #1;
        check_b("post_rst_req", imem_req, 1'b1);
        check("post_rst_addr", imem_addr, RESET_PC);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!InstrValid && n < 30) begin
            tick();
            n++;
        end
        check_b(name, InstrValid, 1'b1);
    endtask

    task automatic wait_req(input string name, input logic [31:0] addr);
        int n = 0;
        while (!imem_req && n < 30) begin
            tick();
            n++;
        end
        check_b({name, "_req"}, imem_req, 1'b1);
        check(name, imem_addr, addr);
    endtask

    task automatic redirect_now(input logic [1:0] src,
                                input logic [31:0] tgt);
        retire = 1'b1;
        PCSrc  = src;
        if (src == PCSRC_ALU) ALUResult = tgt;
        else PCTarget = tgt;
        tick();
        retire = 1'b0;
        PCSrc  = PCSRC_PLUS4;
        check_b("redir_valid_off", InstrValid, 1'b0);
    endtask

    always @(negedge clk) begin
        if (InstrValid) begin
            if (retire) begin
                if (sb_pc.size() == 0) begin
                    check("sb_underflow", PC, 32'hxxxx_xxxx);
                end else begin
                    logic [31:0] ep;
                    logic [31:0] ei;
                    ep = sb_pc.pop_front();
                    ei = sb_instr.pop_front();
                    check("pc", PC, ep);
                    check("instr", Instr, ei);
                    check("pcplus4", PCPlus4, ep + 32'd4);
                end
            end
        end else if (!reset) begin
            check("idle_instr", Instr, NOP_INSTR);
            check("idle_pc", PC, 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int r0;
        reset       = 1'b1;
        retire      = 1'b0;
        PCSrc       = PCSRC_PLUS4;
        PCTarget    = '0;
        ALUResult   = '0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        // Sequential stream, L=1, retire every cycle: no bubbles.
        do_reset();
        retire = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            check_b("seq_valid", InstrValid, t >= 3);
            tick();
        end

        // Retire held low: buffer plus in-flight cap at four.
        do_reset();
        a0 = acc_count;
        repeat (10) tick();
        check("hold_accepts", 32'(acc_count - a0), 32'd4);
        check_b("hold_req", imem_req, 1'b0);
        retire = 1'b1;
        wait_req("resume_addr", 32'h10);
        repeat (10) tick();

        // L=3: redirect with three responses still to come.
        lat_min = 3;
        lat_max = 3;
        do_reset();
        wait_valid("l3_valid");
        r0 = rv_count - int'(imem_rvalid);
        redirect_now(PCSRC_TARGET, 32'h0000_0100);
        wait_req("l3_target", 32'h100);
        check("l3_dropped", 32'(rv_count - r0 - int'(imem_rvalid)), 32'd3);
        retire = 1'b1;
        repeat (12) tick();

        // JALR redirect with a response in the same cycle.
        lat_min = 1;
        lat_max = 1;
        do_reset();
        wait_valid("alu_valid");
        redirect_now(PCSRC_ALU, 32'h0000_0205);
        wait_req("alu_target", 32'h204);
        retire = 1'b1;
        repeat (8) tick();

        // Misaligned target: sticky fault until reset.
        do_reset();
        wait_valid("mis_valid");
        redirect_now(PCSRC_TARGET, 32'h0000_0102);
        for (int i = 0; i < 6; i++) begin
            check_b("fault_set", MisalignFault, 1'b1);
            check_b("fault_noreq", imem_req, 1'b0);
            tick();
        end
        do_reset();

        // Address wrap at the top of memory.
        wait_valid("wrap_valid");
        redirect_now(PCSRC_TARGET, 32'hFFFF_FFFC);
        retire = 1'b1;
        wait_req("wrap_first", 32'hFFFF_FFFC);
        tick();
        wait_req("wrap_next", 32'h0000_0000);
        repeat (8) tick();

        // Random traffic with variable latency and backpressure.
        lat_min   = 1;
        lat_max   = 4;
        ready_pct = 70;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            int r;
            logic [31:0] v;
            if (i == 400) do_reset();
            retire = ($urandom_range(99, 0) < 70);
            r = int'($urandom_range(99, 0));
            PCSrc = (r < 70) ? 2'b00 : (r < 80) ? 2'b01 :
                    (r < 90) ? 2'b10 : 2'b11;
            v = $urandom();
            PCTarget = v & 32'hFFFF_FFFC;
            v = $urandom();
            ALUResult = v & 32'hFFFF_FFFD;
            tick();
        end
        retire = 1'b0;
        PCSrc  = PCSRC_PLUS4;
        repeat (3) tick();
        check("sb_empty", 32'(sb_pc.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the RISC-V core, directly upstream of decode/control. It owns the program counter and issues requests to instruction memory under a req/ready handshake with variable read latency. Returned words are buffered with their PC and presented to decode as `Instr`/`PC`/`InstrValid`. `PCSrc` from control redirects fetch to a new PC, flushing wrong-path instructions.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 4: fetch buffer entries; also the cap on (outstanding requests + buffered entries). Power of two, ≥2.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `retire`  in  1  downstream consumes the head instruction this cycle; ignored when `InstrValid`=0.
- `PCSrc`  in  2  next-PC select for the retiring instruction: 00 PC+4, 01 `PCTarget`, 10 `ALUResult` (JALR), 11 treated as 00.
- `PCTarget`  in  32  branch/JAL target.
- `ALUResult`  in  32  JALR target, before bit-0 clearing.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request word address.
- `imem_ready`  in  1  memory accepts the request when `imem_req`&`imem_ready`.
- `imem_rvalid`  in  1  response valid; responses return in request order, ≥1 cycle after acceptance.
- `imem_rdata`  in  32  response instruction word.
- `Instr`  out  32  head instruction; 32'h0000_0013 (NOP) when `InstrValid`=0.
- `PC`  out  32  address of `Instr`; 0 when `InstrValid`=0.
- `PCPlus4`  out  32  `PC`+4, mod 2^32.
- `InstrValid`  out  1  head entry valid.
- `MisalignFault`  out  1  sticky: a redirect target had bit 1 set.

## Operation
- Registers: `fetch_pc`, `outstanding` count, `drop` count, buffer of {pc, instr}, FSM state.
- FSM states: RUN, DRAIN, FAULT.
- RUN: `imem_req`=1 iff `outstanding`+`count` < DEPTH; `imem_addr`=`fetch_pc`.
  - On accept, `fetch_pc` += 4 (wraps at 2^32) and `outstanding`++.
  - `imem_rvalid`: push {pc of oldest outstanding, `imem_rdata`}; `outstanding`--.
- Redirect = `retire`&`InstrValid`&`PCSrc`∈{01,10}.
  - Target = `PCTarget` (01) or {`ALUResult`[31:1],1'b0} (10).
  - Effects in the same edge: flush buffer; `fetch_pc` ← target; `drop` ← `outstanding` after this cycle's accept/response.
  - Go to DRAIN if `drop`≠0, else RUN.
- DRAIN: `imem_req`=0; each `imem_rvalid` is discarded and decrements `drop`; at `drop`=0, return to RUN.
- Redirect target[1]=1: set `MisalignFault`, flush, enter FAULT. In FAULT: `imem_req`=0, `InstrValid`=0, responses discarded. Exit only via reset.
- Simultaneous events:
  - A response in the redirect cycle is discarded.
  - A request accepted in the redirect cycle counts toward `drop`.
  - `retire` with `PCSrc`=00 pops the head only.
  - Push and pop in the same cycle keep `count` unchanged.
- `imem_rvalid` with `outstanding`=0 in RUN is a protocol error: ignored, with an assertion in the bench.

## Timing
- During reset and in the cycle it is sampled high:
  - `fetch_pc`=RESET_PC, `outstanding`=`drop`=0, buffer empty, state RUN.
  - `InstrValid`=0, `MisalignFault`=0, `Instr`=NOP, `PC`=0.
  - `imem_rvalid` is ignored.
- First cycle after reset: `imem_req`=1, `imem_addr`=RESET_PC.
- Accept at cycle N, `imem_rvalid` at N+L ⇒ `InstrValid` at N+L+1. No bypass; buffer output is registered.
- With DEPTH=4, L=1, `imem_ready`=1 and `retire` every cycle, throughput is one instruction per cycle.
- Redirect at cycle R:
  - `InstrValid`=0 at R+1.
  - With `drop`=0, `imem_req` to target at R+1; first target instruction valid at R+3 with L=1.
- Reset mid-operation: all counts cleared; the memory is reset by the same `reset`, so no stale responses follow.

## Structure
- Shared package `riscv_pkg`:
  - constants `PCSRC_PLUS4`=2'b00, `PCSRC_TARGET`=2'b01, `PCSRC_ALU`=2'b10;
  - `NOP_INSTR`=32'h0000_0013;
  - fetch FSM state enum.
- Sub-module `fetch_fifo`: synchronous FIFO, 64-bit entries {pc, instr}, DEPTH entries, with push/pop/flush, `count`, and registered head output.

## Test plan
- Reset, `imem_ready`=1, L=1, `retire`=1 each cycle, PCSrc=00 → addresses 0,4,8,…; `InstrValid` from cycle 3; PC/Instr pairs match memory; no bubbles.
- `retire` held 0 → exactly 4 requests accepted, `imem_req`=0 afterwards; release → fetch resumes with the next sequential address.
- L=3, redirect PCSrc=01, `PCTarget`=0x100 while 3 requests outstanding → 3 responses discarded; next request 0x100; first valid PC=0x100.
- PCSrc=10, `ALUResult`=0x205 → fetch from 0x204; same-cycle `imem_rvalid` is discarded.
- PCSrc=01, `PCTarget`=0x102 → `MisalignFault`=1, `imem_req`=0 until reset; after reset, fetch restarts at RESET_PC.
- `fetch_pc`=0xFFFF_FFFC → next request 0x0000_0000; `PCPlus4`=0 for PC 0xFFFF_FFFC.
